// File: rtl/vga_sync_rx_pkg.sv
// Shared definitions for the VGA timing receiver: nominal 640x480 @ 800x520
// timing constants, sync polarity, FSM encoding and the debug view struct.
package vga_sync_rx_pkg;

   localparam int unsigned c_pxl_visible   = 640;
   localparam int unsigned c_pxl_2_fporch  = 656;
   localparam int unsigned c_pxl_synch     = 96;
   localparam int unsigned c_pxl_total     = 800;
   localparam int unsigned c_line_visible  = 480;
   localparam int unsigned c_line_2_fporch = 489;
   localparam int unsigned c_line_total    = 520;
   localparam int unsigned c_lock_frames   = 2;
   localparam logic        c_synch_act     = 1'b0;

   // Width counter saturation value.
   localparam logic [9:0]  C_WIDTH_MAX     = 10'd1023;

   typedef enum logic [1:0] {
      S_HUNT   = 2'd0,
      S_CHECK  = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   // Internal view for checkers: FSM state, lock progress and edge pulses.
   typedef struct packed {
      state_t     state;
      logic [3:0] frame_ok;
      logic       hs_lead;
      logic       hs_trail;
      logic       vs_lead;
      logic       vs_trail;
   } dbg_t;

   // Increment with wrap to zero after i_last.
   function automatic logic [9:0] f_wrap_inc(input logic [9:0] i_val,
                                             input logic [9:0] i_last);
      return (i_val == i_last) ? 10'd0 : i_val + 10'd1;
   endfunction

endpackage

// File: rtl/vga_sync_rx_if.sv
// Bus between a sync source (master) and the timing receiver (slave).
// pxl_en is a qualifier, not a handshake: the receiver samples hsync/vsync
// on every clk edge where pxl_en=1 and never back-pressures; each output
// set describes the pixel sampled at the previous clk edge, and err and
// new_frame are single-clk pulses.
interface vga_sync_rx_if;
   import vga_sync_rx_pkg::*;

   logic       pxl_en;
   logic       hsync_in;
   logic       vsync_in;
   logic [9:0] col;
   logic [9:0] row;
   logic       visible;
   logic       locked;
   logic       new_frame;
   logic       err;
   dbg_t       dbg;

   modport master (
      output pxl_en, hsync_in, vsync_in,
      input  col, row, visible, locked, new_frame, err, dbg
   );

   modport slave (
      input  pxl_en, hsync_in, vsync_in,
      output col, row, visible, locked, new_frame, err, dbg
   );

endinterface

// File: rtl/vga_sync_rx_edge.sv
// Sync edge detector: keeps the previously sampled level, flags leading and
// trailing edges of the active level, and optionally measures the active
// width and flags a trailing edge whose width differs from the required one.
module vga_sync_edge
   import vga_sync_rx_pkg::*;
#(
   parameter bit          P_WIDTH_EN  = 1'b0,
   parameter int unsigned P_WIDTH_REQ = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_sync,
   output logic o_lead,
   output logic o_trail,
   output logic o_width_bad
);

   localparam logic [9:0] L_WIDTH_REQ = 10'(P_WIDTH_REQ);

   logic       r_d;
   logic       w_act_now;
   logic       w_act_prev;
   logic [9:0] w_width;

   assign w_act_now  = (i_sync == c_synch_act);
   assign w_act_prev = (r_d == c_synch_act);
   assign o_lead     = i_en & w_act_now & ~w_act_prev;
   assign o_trail    = i_en & ~w_act_now & w_act_prev;

   // Previous sampled level; starts inactive so a sync held active through
   // reset shows up as a leading edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       r_d <= ~c_synch_act;
      else if (i_en) r_d <= i_sync;
   end

   generate
      if (P_WIDTH_EN) begin : g_width
         logic [9:0] r_width;

         // Active-width counter: the leading-edge strobe is the first active
         // pixel, so it restarts at 1; saturates instead of wrapping.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_width <= '0;
            end else if (i_en && w_act_now) begin
               if (!w_act_prev)                r_width <= 10'd1;
               else if (r_width != C_WIDTH_MAX) r_width <= r_width + 10'd1;
            end
         end

         assign w_width = r_width;
      end else begin : g_no_width
         assign w_width = '0;
      end
   endgenerate

   assign o_width_bad = P_WIDTH_EN & o_trail & (w_width != L_WIDTH_REQ);

endmodule

// File: rtl/vga_sync_rx.sv
// VGA timing receiver: recovers col/row from hsync/vsync sampled on the
// pixel strobe, checks edge positions and hsync width against the nominal
// timing, and reports lock after enough clean frames.
module vga_sync_rx
   import vga_sync_rx_pkg::*;
#(
   parameter int unsigned P_PXL_VISIBLE   = c_pxl_visible,
   parameter int unsigned P_PXL_2_FPORCH  = c_pxl_2_fporch,
   parameter int unsigned P_PXL_SYNCH     = c_pxl_synch,
   parameter int unsigned P_PXL_TOTAL     = c_pxl_total,
   parameter int unsigned P_LINE_VISIBLE  = c_line_visible,
   parameter int unsigned P_LINE_2_FPORCH = c_line_2_fporch,
   parameter int unsigned P_LINE_TOTAL    = c_line_total,
   parameter int unsigned P_LOCK_FRAMES   = c_lock_frames
) (
   input logic          clk,
   input logic          rst,
   vga_sync_rx_if.slave vga
);

   localparam logic [9:0] L_PXL_LAST  = 10'(P_PXL_TOTAL - 1);
   localparam logic [9:0] L_LINE_LAST = 10'(P_LINE_TOTAL - 1);
   localparam logic [9:0] L_HS_COL    = 10'(P_PXL_2_FPORCH);
   localparam logic [9:0] L_VS_ROW    = 10'(P_LINE_2_FPORCH);
   localparam logic [9:0] L_PXL_VIS   = 10'(P_PXL_VISIBLE);
   localparam logic [9:0] L_LINE_VIS  = 10'(P_LINE_VISIBLE);
   localparam logic [3:0] L_LOCK      = 4'(P_LOCK_FRAMES);

   logic [9:0] r_col, r_row;
   state_t     r_state, w_state_nxt;
   logic [3:0] r_frame_ok, w_frame_ok_nxt;
   logic       r_err, w_err_nxt;
   logic       r_new_frame, w_new_frame_nxt;

   logic       w_hs_lead, w_hs_trail, w_hs_width_bad;
   logic       w_vs_lead, w_vs_trail, w_vs_width_bad;
   logic [9:0] w_col_fr, w_row_fr, w_col_nxt, w_row_nxt;
   logic       w_viol;
   logic       w_locked;

   vga_sync_edge #(
      .P_WIDTH_EN  (1'b1),
      .P_WIDTH_REQ (P_PXL_SYNCH)
   ) u_hs_edge (
      .clk         (clk),
      .rst         (rst),
      .i_en        (vga.pxl_en),
      .i_sync      (vga.hsync_in),
      .o_lead      (w_hs_lead),
      .o_trail     (w_hs_trail),
      .o_width_bad (w_hs_width_bad)
   );

   vga_sync_edge #(
      .P_WIDTH_EN  (1'b0),
      .P_WIDTH_REQ (0)
   ) u_vs_edge (
      .clk         (clk),
      .rst         (rst),
      .i_en        (vga.pxl_en),
      .i_sync      (vga.vsync_in),
      .o_lead      (w_vs_lead),
      .o_trail     (w_vs_trail),
      .o_width_bad (w_vs_width_bad)
   );

   // Free-run position: row only steps when the column wraps.
   assign w_col_fr = f_wrap_inc(r_col, L_PXL_LAST);
   assign w_row_fr = (r_col == L_PXL_LAST) ? f_wrap_inc(r_row, L_LINE_LAST) : r_row;

   // Sync leading edges re-anchor the position and win over the free-run value.
   assign w_col_nxt = w_hs_lead ? L_HS_COL : w_col_fr;
   assign w_row_nxt = w_vs_lead ? L_VS_ROW : w_row_fr;

   // A violation is an edge landing somewhere the free-run count did not predict,
   // or an hsync pulse of the wrong width.
   assign w_viol = (w_hs_lead && (w_col_fr != L_HS_COL)) ||
                   (w_vs_lead && (w_row_fr != L_VS_ROW)) ||
                   w_hs_width_bad || w_vs_width_bad;

   // Lock FSM next state, frame counter and pulse outputs.
   always_comb begin
      w_state_nxt    = r_state;
      w_frame_ok_nxt = r_frame_ok;
      w_err_nxt      = 1'b0;
      if (vga.pxl_en) begin
         case (r_state)
            S_HUNT: begin
               if (w_vs_lead) begin
                  w_state_nxt    = S_CHECK;
                  w_frame_ok_nxt = '0;
               end
            end
            S_CHECK: begin
               if (w_viol) begin
                  w_state_nxt = S_HUNT;
                  w_err_nxt   = 1'b1;
               end else if (w_vs_lead) begin
                  w_frame_ok_nxt = r_frame_ok + 4'd1;
                  if (w_frame_ok_nxt == L_LOCK) w_state_nxt = S_LOCKED;
               end
            end
            S_LOCKED: begin
               if (w_viol) begin
                  w_state_nxt = S_HUNT;
                  w_err_nxt   = 1'b1;
               end
            end
            default: w_state_nxt = S_HUNT;
         endcase
      end
      w_new_frame_nxt = vga.pxl_en && (w_state_nxt == S_LOCKED) &&
                        (w_col_nxt == '0) && (w_row_nxt == '0);
   end

   // FSM state and clean-frame counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_HUNT;
         r_frame_ok <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_frame_ok <= w_frame_ok_nxt;
      end
   end

   // Recovered position, advanced only on the pixel strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (vga.pxl_en) begin
         r_col <= w_col_nxt;
         r_row <= w_row_nxt;
      end
   end

   // Single-clk pulses; the next-state terms are zero without a strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err       <= 1'b0;
         r_new_frame <= 1'b0;
      end else begin
         r_err       <= w_err_nxt;
         r_new_frame <= w_new_frame_nxt;
      end
   end

   assign w_locked      = (r_state == S_LOCKED);
   assign vga.col       = r_col;
   assign vga.row       = r_row;
   assign vga.locked    = w_locked;
   assign vga.visible   = w_locked && (r_col < L_PXL_VIS) && (r_row < L_LINE_VIS);
   assign vga.err       = r_err;
   assign vga.new_frame = r_new_frame;
   assign vga.dbg       = '{state:    r_state,
                            frame_ok: r_frame_ok,
                            hs_lead:  w_hs_lead,
                            hs_trail: w_hs_trail,
                            vs_lead:  w_vs_lead,
                            vs_trail: w_vs_trail};

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx on a scaled-down timing (48x16 pixels/lines) so
// several frames fit in a short run. A directed sync generator drives one
// pixel every two clks and pushes the expected output set per strobe; a
// monitor pops and compares after every strobe and checks holds otherwise.
module tb_vga_sync_rx;
   import vga_sync_rx_pkg::*;

   localparam int PV        = 32;  // visible pixels
   localparam int PF        = 36;  // hsync leading column
   localparam int PS        = 4;   // hsync width
   localparam int PT        = 48;  // pixels per line
   localparam int LV        = 12;  // visible lines
   localparam int LF        = 14;  // vsync leading row
   localparam int LT        = 16;  // lines per frame
   localparam int VS_LINES  = 2;   // vsync width in lines
   localparam int LOCK_EDGE = 3;   // vsync leading edge that brings lock

   typedef struct packed {
      logic       chk_pos;
      logic       chk_vis;
      logic [9:0] col;
      logic [9:0] row;
      logic       vis;
      logic       locked;
      logic       nf;
      logic       err;
   } exp_t;
   localparam int EXP_W = $bits(exp_t);

   logic [EXP_W-1:0] exp_q[$];

   logic clk      = 1'b0;
   logic rst      = 1'b0;
   bit   clk_run  = 1'b0;
   logic strobe_q = 1'b0;
   int   total    = 0;
   int   bad      = 0;

   // generator / expectation state
   bit prev_hs_act   = 1'b0;
   bit prev_vs_act   = 1'b0;
   int vs_cnt        = 0;
   bit exp_locked    = 1'b0;
   bit mask          = 1'b0;
   bit arm_hlead_err = 1'b0;

   vga_sync_rx_if vga();

   vga_sync_rx #(
      .P_PXL_VISIBLE   (PV),
      .P_PXL_2_FPORCH  (PF),
      .P_PXL_SYNCH     (PS),
      .P_PXL_TOTAL     (PT),
      .P_LINE_VISIBLE  (LV),
      .P_LINE_2_FPORCH (LF),
      .P_LINE_TOTAL    (LT),
      .P_LOCK_FRAMES   (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .vga (vga)
   );

   // clock, started only after the clockless reset check
   initial begin
      wait (clk_run);
      forever #10 clk = ~clk;
   end

   always @(posedge clk) strobe_q <= vga.pxl_en;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // one pixel: compute syncs, push expectation, strobe, then one idle clk
   task automatic send_pixel(input int c, input int r, input bit short_hs, input bit short_err);
      int   hs_w;
      bit   hs_act, vs_act, hs_lead, hs_trail, vs_lead, err_e;
      exp_t e;
      hs_w     = short_hs ? PS - 1 : PS;
      hs_act   = (c >= PF) && (c < PF + hs_w);
      vs_act   = (r >= LF) && (r < LF + VS_LINES);
      hs_lead  = hs_act && !prev_hs_act;
      hs_trail = !hs_act && prev_hs_act;
      vs_lead  = vs_act && !prev_vs_act;
      err_e    = 1'b0;
      if (arm_hlead_err && hs_lead) begin
         err_e         = 1'b1;
         arm_hlead_err = 1'b0;
      end
      if (short_hs && short_err && hs_trail) err_e = 1'b1;
      if (c == PT) begin
         mask          = 1'b1;
         arm_hlead_err = 1'b1;
      end
      if (err_e) begin
         vs_cnt     = 0;
         exp_locked = 1'b0;
         mask       = 1'b0;
      end else if (vs_lead) begin
         vs_cnt++;
         if (vs_cnt >= LOCK_EDGE) exp_locked = 1'b1;
      end
      e.err     = err_e;
      e.locked  = exp_locked;
      e.nf      = exp_locked && (c == 0) && (r == 0);
      e.chk_vis = !mask;
      e.vis     = exp_locked && (c < PV) && (r < LV);
      e.chk_pos = exp_locked && !mask;
      e.col     = 10'(c);
      e.row     = 10'(r);
      exp_q.push_back(e);
      vga.hsync_in = hs_act ? c_synch_act : ~c_synch_act;
      vga.vsync_in = vs_act ? c_synch_act : ~c_synch_act;
      vga.pxl_en   = 1'b1;
      prev_hs_act  = hs_act;
      prev_vs_act  = vs_act;
      @(posedge clk);
      #1 vga.pxl_en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_col"},       vga.col,       0);
      chk({tag, "_row"},       vga.row,       0);
      chk({tag, "_visible"},   vga.visible,   0);
      chk({tag, "_locked"},    vga.locked,    0);
      chk({tag, "_new_frame"}, vga.new_frame, 0);
      chk({tag, "_err"},       vga.err,       0);
   endtask

   // monitor / scoreboard
   initial begin
      exp_t e;
      exp_t last_e;
      bit   last_ok;
      last_ok = 1'b0;
      last_e  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_ok = 1'b0;
         end else if (strobe_q) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL queue: strobe seen with no expectation at t=%0t", $time);
            end else begin
               e = exp_t'(exp_q.pop_front());
               chk("err",       vga.err,       e.err);
               chk("new_frame", vga.new_frame, e.nf);
               chk("locked",    vga.locked,    e.locked);
               if (e.chk_vis) chk("visible", vga.visible, e.vis);
               if (e.chk_pos) begin
                  chk("col", vga.col, e.col);
                  chk("row", vga.row, e.row);
               end
               last_e  = e;
               last_ok = 1'b1;
            end
         end else begin
            chk("err_idle",       vga.err,       0);
            chk("new_frame_idle", vga.new_frame, 0);
            if (last_ok && last_e.chk_pos) begin
               chk("col_hold", vga.col, last_e.col);
               chk("row_hold", vga.row, last_e.row);
            end
         end
      end
   end

   // stimulus
   initial begin
      vga.pxl_en   = 1'b0;
      vga.hsync_in = ~c_synch_act;
      vga.vsync_in = ~c_synch_act;
      #1 rst = 1'b1;
      #4 chk_outputs_zero("rst_noclk");
      clk_run = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int f = 0; f < 12; f++) begin
         for (int r = 0; r < ((f == 11) ? 2 : LT); r++) begin
            int len;
            bit short_hs;
            len      = ((f == 3) && (r == 5)) ? PT + 1 : PT;
            short_hs = (r == 2) && ((f == 0) || (f == 5));
            for (int c = 0; c < len; c++) begin
               if ((f == 8) && (r == 4) && (c == 10)) begin
                  repeat (37) @(posedge clk);
                  #1;
               end
               if ((f == 8) && (r == 7) && (c == 5)) begin
                  #3 rst = 1'b1;
                  #1 chk_outputs_zero("rst_mid");
                  repeat (2) @(posedge clk);
                  #1 rst = 1'b0;
                  vs_cnt     = 0;
                  exp_locked = 1'b0;
                  mask       = 1'b0;
               end
               send_pixel(c, r, short_hs, (f == 5));
            end
         end
      end

      repeat (4) @(posedge clk);
      #1 chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_sync_rx.md
# vga_sync_rx

VGA timing receiver: samples an incoming hsync/vsync pair on a pixel strobe, recovers the column/row position of every pixel, checks the stream against the team's 640x480 @ 800x520 timing, and reports lock. It sits at the input of the capture path, either behind the camera/video front end or in loopback from the VGA sync generator. Downstream capture and framebuffer logic use `col`/`row`/`visible` only while `locked` is high.

## Interface
- `c_pxl_visible`, 640: visible pixels per line
- `c_pxl_2_fporch`, 656: column of the hsync leading edge
- `c_pxl_synch`, 96: required hsync width, in pixels
- `c_pxl_total`, 800: pixels per line
- `c_line_visible`, 480: visible lines
- `c_line_2_fporch`, 489: row of the vsync leading edge
- `c_line_total`, 520: lines per frame
- `c_lock_frames`, 2: consecutive error-free frames required for lock
- `c_synch_act`, 0: active level of hsync/vsync
- `clk` in 1: 50 MHz system clock
- `rst` in 1: reset; asynchronous, active-high
- `pxl_en` in 1: pixel strobe; one clk-wide pulse per pixel; inputs are sampled only on this strobe
- `hsync_in` in 1: horizontal sync, already synchronous to `clk`
- `vsync_in` in 1: vertical sync, already synchronous to `clk`
- `col` out 10: recovered column of the last sampled pixel
- `row` out 10: recovered row of the last sampled pixel
- `visible` out 1: `locked` && `col` < `c_pxl_visible` && `row` < `c_line_visible`
- `locked` out 1: timing lock established
- `new_frame` out 1: one-clk pulse when the position wraps to (0,0) while locked
- `err` out 1: one-clk pulse on any timing violation in CHECK or LOCKED

## Operation
- All state advances only on clk edges where `pxl_en`=1. With `pxl_en`=0, every register except the one-clk pulses holds its value.
- `hs_d`/`vs_d` hold the previously sampled sync levels.
  - Leading edge: previous level inactive, current level active.
  - Trailing edge: previous level active, current level inactive.
- Free-run rule:
  - `col` = `col`==`c_pxl_total`-1 ? 0 : `col`+1.
  - `row` advances (wrapping at `c_line_total`-1) only when `col` wraps.
- Anchoring:
  - hsync leading edge: `col` <= `c_pxl_2_fporch`.
  - vsync leading edge: `row` <= `c_line_2_fporch`.
  - An anchor overrides the free-run value.
  - hsync and vsync anchors on the same strobe both apply.
- Checks, active only in CHECK and LOCKED:
  - hsync leading edge where the free-run next `col` != `c_pxl_2_fporch`.
  - vsync leading edge where the free-run next `row` != `c_line_2_fporch`.
  - hsync trailing edge where the active-width counter != `c_pxl_synch`.
  - The width counter clears on each leading edge and increments on each strobe while hsync is active. It saturates at 1023.
- State machine:
  - HUNT to CHECK on the first vsync leading edge. `frame_ok` is cleared.
  - CHECK: each vsync leading edge with no error since the previous one increments `frame_ok`. When `frame_ok` reaches `c_lock_frames`, go to LOCKED. Any error returns to HUNT.
  - LOCKED: any error drives `err`, clears `locked` and returns to HUNT.
- `new_frame` pulses on the strobe where `col` and `row` both become 0 in LOCKED.

## Timing
- Reset values: `col`=0, `row`=0, `visible`=0, `locked`=0, `new_frame`=0, `err`=0. `hs_d`/`vs_d` reset to the inactive level, the width counter and `frame_ok` to 0, and the state to HUNT.
- Latency: outputs describe the pixel sampled at the previous clk edge (one clk, zero pixels). `err` and `new_frame` are registered pulses issued on that same edge.
- `locked` rises on the clk edge of the (`c_lock_frames`+1)-th vsync leading edge after reset or after an error.
- Reset asserted mid-frame clears all outputs immediately, without waiting for a clk edge. Re-lock then follows the normal HUNT sequence.
- Loss of sync (no edges) is not flagged. Position free-runs and lock is retained.

## Structure
- Shared header `vga_timing_defs.vh` holds the timing constants and `c_synch_act`. It is used by both this block and the sync generator.
- Sub-module `vga_sync_edge`, instantiated once per sync:
  - registers the sampled level;
  - emits leading and trailing edge pulses;
  - carries an optional width counter, enabled for hsync.
- State encoding is local to this block: HUNT=0, CHECK=1, LOCKED=2.

## Test plan
- Reset: assert `rst` with no clk running → all outputs 0 asynchronously.
- Loopback from the sync generator (50 MHz, `pxl_en` = its `new_pxl`):
  - `locked` rises at the 3rd vsync leading edge, with `row`=489 and `col`=0.
  - Afterwards, `col`/`row`/`visible` match the generator on every strobe.
  - `new_frame` occurs every 416000 strobes.
- While locked, insert one 801-pixel line → `err` pulses at the next hsync leading edge and `locked`=0. Re-lock occurs 3 vsync edges later.
- While in CHECK, shorten one hsync pulse to 95 pixels → `err` at its trailing edge and the state returns to HUNT. `locked` never rises in that frame.
- Hold `pxl_en` low for 37 clks mid-line → `col`/`row` frozen, no `err`.
- Assert `rst` mid-frame while locked → outputs 0 immediately. After release, `locked` returns 3 vsync edges later.
